genvar_chan_counter_bank: RTL and testbench

- Parametrised bank of NCH event counters built from a genvar loop with named generate blocks (chan[i]).
- Channel i has a per-iteration localparam width `W0+i`, so every channel is a different width.
- A snapshot/readout FSM serialises all channel counts over a valid/ready stream, zero-extended to the widest channel.
- Serves as the sequential elaboration workload for per-iteration localparam widths, genvar-scoped names and hierarchical references into generate scopes.

---
 rtl/genvar_chan_counter_bank.sv | 149 ++++++++++++++
 tb/tb_genvar_chan_counter_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genvar_chan_counter_bank.sv
// Bank of NCH event counters (channel i is W0+i bits wide), read out through a snapshot and valid/ready stream.
// Optional GENBANK_OVF_FLAG_EN adds sticky per-channel overflow flags, carried in the MSB of each beat.
module genvar_chan_counter_bank #(
    parameter  int NCH  = 4,
    parameter  int W0   = 2,
    parameter  int SAT  = 0,
    localparam int MAXW = W0 + NCH - 1,
`ifdef GENBANK_OVF_FLAG_EN
    localparam int OW   = MAXW + 1
`else
    localparam int OW   = MAXW
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  inc,
    input  logic [NCH-1:0]  clr,
    input  logic            start,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_idx,
    output logic [OW-1:0]   out_data,
    output logic            out_last
`ifdef GENBANK_OVF_FLAG_EN
    ,
    output logic [NCH-1:0]  ovf
`endif
);

    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NCH - 1);

    state_t          r_state;
    logic [2:0]      r_idx;
    logic            w_snapEn;
    logic [OW-1:0]   w_beat [8];

    assign w_snapEn = (r_state == SNAP);

    for (genvar i = 0; i < NCH; i++) begin : chan
        localparam int             CW   = W0 + i;
        localparam logic [CW-1:0]  CMAX = '1;

        logic [CW-1:0] cnt;
        logic [CW-1:0] snap;
        logic [CW-1:0] w_cntNext;
        logic          w_atMax;

        assign w_atMax = (cnt == CMAX);

        // The snapshot takes the post-update value, so an inc in the SNAP cycle is included.
        always_comb begin
            w_cntNext = cnt;
            if (clr[i])
                w_cntNext = '0;
            else if (inc[i]) begin
                if (SAT != 0 && w_atMax)
                    w_cntNext = cnt;
                else
                    w_cntNext = cnt + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                snap <= '0;
            end else begin
                cnt <= w_cntNext;
                if (w_snapEn)
                    snap <= w_cntNext;
            end
        end

`ifdef GENBANK_OVF_FLAG_EN
        logic r_ovf;
        logic r_snapOvf;
        logic w_ovfNext;

        assign w_ovfNext = clr[i] ? 1'b0 : (r_ovf | (inc[i] & w_atMax));
        assign ovf[i]    = r_ovf;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ovf     <= 1'b0;
                r_snapOvf <= 1'b0;
            end else begin
                r_ovf <= w_ovfNext;
                if (w_snapEn)
                    r_snapOvf <= w_ovfNext;
            end
        end
`endif
    end

    // Readout reaches into each channel scope; unused mux slots read as zero.
    for (genvar k = 0; k < NCH; k++) begin : readout
`ifdef GENBANK_OVF_FLAG_EN
        assign w_beat[k] = {chan[k].r_snapOvf, MAXW'(chan[k].snap)};
`else
        assign w_beat[k] = OW'(chan[k].snap);
`endif
    end

    for (genvar j = NCH; j < 8; j++) begin : pad
        assign w_beat[j] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start)
                        r_state <= SNAP;
                end
                SNAP: begin
                    r_idx   <= '0;
                    r_state <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == SEND);
    assign out_idx   = out_valid ? r_idx : 3'd0;
    assign out_last  = out_valid && (r_idx == LAST_IDX);
    assign out_data  = out_valid ? w_beat[r_idx] : '0;

endmodule

// File: tb/tb_genvar_chan_counter_bank.sv
// Self-checking bench: a wrapping and a saturating bank share one stimulus stream and are
// compared every cycle against a queue-based readout model.
module tb_genvar_chan_counter_bank;

    localparam int NCH  = 4;
    localparam int W0   = 2;
    localparam int MAXW = W0 + NCH - 1;
`ifdef GENBANK_OVF_FLAG_EN
    localparam int OW   = MAXW + 1;
`else
    localparam int OW   = MAXW;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  inc, clr;
    logic            start, outReady;

    logic            busy0, valid0, last0, busy1, valid1, last1;
    logic [2:0]      idx0, idx1;
    logic [OW-1:0]   data0, data1;
`ifdef GENBANK_OVF_FLAG_EN
    logic [NCH-1:0]  ovf0, ovf1;
`endif

    int numCompared   = 0;
    int numMismatched = 0;

    int mCnt0 [NCH];
    int mCnt1 [NCH];
    bit mOvf0 [NCH];
    bit mOvf1 [NCH];
    int q0 [$];
    int q1 [$];
    bit mSnapPending;

    always #5 clk = ~clk;

    genvar_chan_counter_bank #(.NCH(NCH), .W0(W0), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .start(start),
        .busy(busy0), .out_valid(valid0), .out_ready(outReady),
        .out_idx(idx0), .out_data(data0), .out_last(last0)
`ifdef GENBANK_OVF_FLAG_EN
        , .ovf(ovf0)
`endif
    );

    genvar_chan_counter_bank #(.NCH(NCH), .W0(W0), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .start(start),
        .busy(busy1), .out_valid(valid1), .out_ready(outReady),
        .out_idx(idx1), .out_data(data1), .out_last(last1)
`ifdef GENBANK_OVF_FLAG_EN
        , .ovf(ovf1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit modelBusy();
        return mSnapPending || (q0.size() > 0);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            mCnt0[i] = 0; mCnt1[i] = 0; mOvf0[i] = 0; mOvf1[i] = 0;
        end
        q0.delete();
        q1.delete();
        mSnapPending = 0;
    endtask

    task automatic modelStep(input logic [NCH-1:0] incV, input logic [NCH-1:0] clrV,
                             input logic startV, input logic readyV);
        for (int i = 0; i < NCH; i++) begin
            automatic int mx = (1 << (W0 + i)) - 1;
            if (clrV[i]) begin
                mCnt0[i] = 0; mCnt1[i] = 0; mOvf0[i] = 0; mOvf1[i] = 0;
            end else if (incV[i]) begin
                if (mCnt0[i] == mx) begin
                    mCnt0[i] = 0;
                    mOvf0[i] = 1;
                end else
                    mCnt0[i]++;
                if (mCnt1[i] == mx)
                    mOvf1[i] = 1;
                else
                    mCnt1[i]++;
            end
        end
        if (q0.size() > 0) begin
            if (readyV) begin
                q0.delete(0);
                q1.delete(0);
            end
        end else if (mSnapPending) begin
            for (int i = 0; i < NCH; i++) begin
`ifdef GENBANK_OVF_FLAG_EN
                q0.push_back(mCnt0[i] | (int'(mOvf0[i]) << MAXW));
                q1.push_back(mCnt1[i] | (int'(mOvf1[i]) << MAXW));
`else
                q0.push_back(mCnt0[i]);
                q1.push_back(mCnt1[i]);
`endif
            end
            mSnapPending = 0;
        end else if (startV) begin
            mSnapPending = 1;
        end
    endtask

    task automatic checkAll();
        automatic bit expValid = (q0.size() > 0);
        automatic bit expBusy  = modelBusy();
        checkOutput("d0.valid", 32'(valid0), 32'(expValid));
        checkOutput("d1.valid", 32'(valid1), 32'(expValid));
        checkOutput("d0.busy",  32'(busy0),  32'(expBusy));
        checkOutput("d1.busy",  32'(busy1),  32'(expBusy));
        if (expValid) begin
            checkOutput("d0.idx",  32'(idx0),  32'(NCH - q0.size()));
            checkOutput("d1.idx",  32'(idx1),  32'(NCH - q1.size()));
            checkOutput("d0.data", 32'(data0), 32'(q0[0]));
            checkOutput("d1.data", 32'(data1), 32'(q1[0]));
            checkOutput("d0.last", 32'(last0), 32'(q0.size() == 1));
            checkOutput("d1.last", 32'(last1), 32'(q1.size() == 1));
        end
`ifdef GENBANK_OVF_FLAG_EN
        for (int i = 0; i < NCH; i++) begin
            checkOutput("d0.ovf", 32'(ovf0[i]), 32'(mOvf0[i]));
            checkOutput("d1.ovf", 32'(ovf1[i]), 32'(mOvf1[i]));
        end
`endif
    endtask

    task automatic checkResetZeros();
        checkOutput("rst.d0.valid", 32'(valid0), 32'd0);
        checkOutput("rst.d0.busy",  32'(busy0),  32'd0);
        checkOutput("rst.d0.last",  32'(last0),  32'd0);
        checkOutput("rst.d0.idx",   32'(idx0),   32'd0);
        checkOutput("rst.d0.data",  32'(data0),  32'd0);
        checkOutput("rst.d1.valid", 32'(valid1), 32'd0);
        checkOutput("rst.d1.data",  32'(data1),  32'd0);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] incV, input logic [NCH-1:0] clrV,
                                 input logic startV, input logic readyV);
        @(negedge clk);
        checkAll();
        inc = incV; clr = clrV; start = startV; outReady = readyV;
        @(posedge clk);
        modelStep(incV, clrV, startV, readyV);
    endtask

    // Asynchronous reset lands between edges so the immediate clearing is observable.
    task automatic doReset();
        @(negedge clk);
        checkAll();
        inc = '0; clr = '0; start = 1'b0;
        #2 rst = 1'b1;
        #1 checkResetZeros();
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && modelBusy(); n++)
            applyStimulus('0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int stall;
        rst = 1'b1; inc = '0; clr = '0; start = 1'b0; outReady = 1'b1;
        modelReset();
        @(negedge clk);
        checkResetZeros();
        rst = 1'b0;

        for (int k = 0; k < 31; k++)
            applyStimulus({1'b1, 2'b00, k < 5}, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        drain();

        for (int k = 0; k < 20; k++)
            applyStimulus(4'b0010, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        drain();

        applyStimulus(4'b0100, '0, 1'b0, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        drain();

        applyStimulus(4'b0100, '0, 1'b1, 1'b1);
        stall = 0;
        for (int n = 0; n < 20 && modelBusy(); n++) begin
            if (q0.size() == 2 && stall < 3) begin
                stall++;
                applyStimulus(4'b0100, '0, 1'b0, 1'b0);
            end else
                applyStimulus('0, '0, 1'b0, 1'b1);
        end

        applyStimulus('0, 4'b1000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            applyStimulus(4'b1000, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(4'b1000, '0, 1'b0, 1'b1);
        for (int n = 0; n < 20 && modelBusy(); n++)
            applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b1, 1'b1);
        drain();

        applyStimulus(4'b1111, '0, 1'b1, 1'b1);
        for (int n = 0; n < 20 && q0.size() != 3; n++)
            applyStimulus('0, '0, 1'b0, 1'b1);
        doReset();
        applyStimulus('0, '0, 1'b1, 1'b1);
        drain();

        for (int n = 0; n < 400; n++) begin
            automatic logic [NCH-1:0] c = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
            applyStimulus(NCH'($urandom), c, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

        @(negedge clk);
        checkAll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
